// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes, ULA codes, mux selects, states.
// Pure declarations; no timing or flow-control behaviour of its own.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_RESULT = 2'b00;
  localparam logic [1:0] PCSRC_ULAOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXEC_R   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_EXEC_I   = 4'd9,
    S_ALUI_WB  = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

endpackage

// File: rtl/ula_funct_decoder.sv
// Maps an R-type funct field to the ULA operation and flags funct codes the datapath cannot execute.
// Purely combinational, zero latency; no handshake.
module ula_funct_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int FUNCT_W    = 6,
  parameter int ULA_CTRL_W = 3
) (
  input  logic [FUNCT_W-1:0]    funct_i,
  output logic [ULA_CTRL_W-1:0] ula_ctrl_o,
  output logic                  legal_o
);

  always_comb begin
    ula_ctrl_o = ULA_CTRL_W'(ULA_ADD);
    legal_o    = 1'b1;
    case (funct_i)
      FUNCT_W'(FN_ADD): ula_ctrl_o = ULA_CTRL_W'(ULA_ADD);
      FUNCT_W'(FN_SUB): ula_ctrl_o = ULA_CTRL_W'(ULA_SUB);
      FUNCT_W'(FN_AND): ula_ctrl_o = ULA_CTRL_W'(ULA_AND);
      FUNCT_W'(FN_OR):  ula_ctrl_o = ULA_CTRL_W'(ULA_OR);
      FUNCT_W'(FN_SLT): ula_ctrl_o = ULA_CTRL_W'(ULA_SLT);
      default:          legal_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS controller: sequences each instruction over 3-5 states onto a shared ULA and unified memory.
// Memory states hold until mem_ready; each wait cycle adds one cycle to the instruction.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W       = 6,
  parameter int FUNCT_W    = 6,
  parameter int ULA_CTRL_W = 3,
  parameter int RET_CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OP_W-1:0]       OP,
  input  logic [FUNCT_W-1:0]    Funct,
  input  logic                  Zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  MemWrite,
  output logic                  IorD,
  output logic                  IRWrite,
  output logic                  PCEn,
  output logic [1:0]            PCSrc,
  output logic                  ULASrcA,
  output logic [1:0]            ULASrcB,
  output logic [ULA_CTRL_W-1:0] ULAControl,
  output logic                  RegDst,
  output logic                  MemtoReg,
  output logic                  RegWrite,
  output logic                  illegal_op,
  output logic [RET_CNT_W-1:0]  retired
);

  state_e                 state_q, state_d;
  logic [RET_CNT_W-1:0]   retired_q, retired_d;
  logic                   retire;
  logic [ULA_CTRL_W-1:0]  r_ctrl;
  logic                   funct_legal;

  ula_funct_decoder #(
    .FUNCT_W    (FUNCT_W),
    .ULA_CTRL_W (ULA_CTRL_W)
  ) u_funct_dec (
    .funct_i    (Funct),
    .ula_ctrl_o (r_ctrl),
    .legal_o    (funct_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired_d = retire ? retired_q + RET_CNT_W'(1) : retired_q;
  assign retired   = retired_q;

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCEn       = 1'b0;
    PCSrc      = PCSRC_RESULT;
    ULASrcA    = 1'b0;
    ULASrcB    = SRCB_B;
    ULAControl = '0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      // PC+4 is computed while the instruction is read; both commit on mem_ready.
      S_FETCH: begin
        mem_req    = 1'b1;
        ULASrcB    = SRCB_FOUR;
        ULAControl = ULA_CTRL_W'(ULA_ADD);
        IRWrite    = mem_ready;
        PCEn       = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        ULASrcB    = SRCB_IMM_SH;
        ULAControl = ULA_CTRL_W'(ULA_ADD);
        case (OP)
          OP_W'(OP_LW), OP_W'(OP_SW): state_d = S_MEMADR;
          OP_W'(OP_RTYPE): begin
            if (funct_legal) begin
              state_d = S_EXEC_R;
            end else begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          end
          OP_W'(OP_BEQ), OP_W'(OP_BNE): state_d = S_BRANCH;
          OP_W'(OP_ADDI), OP_W'(OP_ANDI),
          OP_W'(OP_ORI), OP_W'(OP_SLTI): state_d = S_EXEC_I;
          OP_W'(OP_J): state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        ULASrcA    = 1'b1;
        ULASrcB    = SRCB_IMM;
        ULAControl = ULA_CTRL_W'(ULA_ADD);
        if (OP == OP_W'(OP_LW))      state_d = S_MEMREAD;
        else if (OP == OP_W'(OP_SW)) state_d = S_MEMWRITE;
        else                         state_d = S_FETCH;
      end

      S_MEMREAD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_EXEC_R: begin
        ULASrcA    = 1'b1;
        ULASrcB    = SRCB_B;
        ULAControl = r_ctrl;
        state_d    = S_ALU_WB;
      end

      S_ALU_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_EXEC_I: begin
        ULASrcA = 1'b1;
        ULASrcB = SRCB_IMM;
        case (OP)
          OP_W'(OP_ANDI): ULAControl = ULA_CTRL_W'(ULA_AND);
          OP_W'(OP_ORI):  ULAControl = ULA_CTRL_W'(ULA_OR);
          OP_W'(OP_SLTI): ULAControl = ULA_CTRL_W'(ULA_SLT);
          default:        ULAControl = ULA_CTRL_W'(ULA_ADD);
        endcase
        state_d = S_ALUI_WB;
      end

      S_ALUI_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      // Branch target was parked in ULAOut during DECODE; the subtract resolves the condition.
      S_BRANCH: begin
        ULASrcA    = 1'b1;
        ULASrcB    = SRCB_B;
        ULAControl = ULA_CTRL_W'(ULA_SUB);
        PCSrc      = PCSRC_ULAOUT;
        PCEn       = (OP == OP_W'(OP_BEQ)) ? Zero : !Zero;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCEn    = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each scenario queues per-cycle stimulus plus expected controls, then replays and compares.
// Uses a 2-bit retired counter so wrap-around is reached quickly.
module tb_multicycle_control_unit;

  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    OP = 6'd0;
  logic [5:0]    Funct = 6'd0;
  logic          Zero = 1'b0;
  logic          mem_ready = 1'b1;
  logic          mem_req, MemWrite, IorD, IRWrite, PCEn, ULASrcA;
  logic          RegDst, MemtoReg, RegWrite, illegal_op;
  logic [1:0]    PCSrc, ULASrcB;
  logic [2:0]    ULAControl;
  logic [RW-1:0] retired;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .OP_W(6), .FUNCT_W(6), .ULA_CTRL_W(3), .RET_CNT_W(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCEn(PCEn),
    .PCSrc(PCSrc), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB), .ULAControl(ULAControl),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .illegal_op(illegal_op),
    .retired(retired)
  );

  typedef struct packed {
    logic       mem_req;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       PCEn;
    logic [1:0] PCSrc;
    logic       ULASrcA;
    logic [1:0] ULASrcB;
    logic [2:0] ULAControl;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       illegal_op;
  } ctl_t;

  typedef struct packed {
    ctl_t          c;
    logic [RW-1:0] ret;
    logic          rdy;
    logic          zero;
  } ent_t;

  ctl_t          obs;
  ent_t          sb[$];
  ent_t          e;
  logic [RW-1:0] exp_ret = '0;
  int            checks = 0;
  int            errors = 0;

  assign obs = {mem_req, MemWrite, IorD, IRWrite, PCEn, PCSrc, ULASrcA, ULASrcB,
                ULAControl, RegDst, MemtoReg, RegWrite, illegal_op};

  // Expected control words, written straight from the state table.
  function automatic ctl_t c_zero();
    ctl_t c = '0; return c;
  endfunction
  function automatic ctl_t c_fetch(logic rdy);
    ctl_t c = '0; c.mem_req = 1; c.IRWrite = rdy; c.PCEn = rdy; c.ULASrcB = 2'b01; c.ULAControl = 3'b010; return c;
  endfunction
  function automatic ctl_t c_decode(logic ill);
    ctl_t c = '0; c.ULASrcB = 2'b11; c.ULAControl = 3'b010; c.illegal_op = ill; return c;
  endfunction
  function automatic ctl_t c_memadr();
    ctl_t c = '0; c.ULASrcA = 1; c.ULASrcB = 2'b10; c.ULAControl = 3'b010; return c;
  endfunction
  function automatic ctl_t c_memread();
    ctl_t c = '0; c.mem_req = 1; c.IorD = 1; return c;
  endfunction
  function automatic ctl_t c_memwb();
    ctl_t c = '0; c.RegWrite = 1; c.MemtoReg = 1; return c;
  endfunction
  function automatic ctl_t c_memwrite();
    ctl_t c = '0; c.mem_req = 1; c.MemWrite = 1; c.IorD = 1; return c;
  endfunction
  function automatic ctl_t c_exec(logic [2:0] ctl, logic [1:0] srcb);
    ctl_t c = '0; c.ULASrcA = 1; c.ULASrcB = srcb; c.ULAControl = ctl; return c;
  endfunction
  function automatic ctl_t c_wb(logic rd);
    ctl_t c = '0; c.RegDst = rd; c.RegWrite = 1; return c;
  endfunction
  function automatic ctl_t c_branch(logic pcen);
    ctl_t c = '0; c.ULASrcA = 1; c.ULAControl = 3'b110; c.PCSrc = 2'b01; c.PCEn = pcen; return c;
  endfunction
  function automatic ctl_t c_jump();
    ctl_t c = '0; c.PCSrc = 2'b10; c.PCEn = 1; return c;
  endfunction

  function automatic void push(ctl_t c, logic rdy, logic z, logic fin);
    ent_t n;
    n.c = c; n.ret = exp_ret; n.rdy = rdy; n.zero = z;
    sb.push_back(n);
    if (fin) exp_ret = exp_ret + RW'(1);
  endfunction

  task automatic test_reset();
    int n = 0;
    exp_ret = '0;
    @(posedge clk); #1;
    push(c_zero(), 1, 0, 0); push(c_zero(), 1, 0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); mem_ready = e.rdy; Zero = e.zero;
      @(negedge clk); checks++;
      if (obs !== e.c || retired !== e.ret) begin errors++;
        $display("FAIL reset_held cyc%0d: ctl=%05h ret=%0d, expected ctl=%05h ret=%0d", n, obs, retired, e.c, e.ret); end
      n++; @(posedge clk); #1;
    end
    rst_n = 1'b1;
    push(c_zero(), 1, 0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); mem_ready = e.rdy; Zero = e.zero;
      @(negedge clk); checks++;
      if (obs !== e.c || retired !== e.ret) begin errors++;
        $display("FAIL reset_release cyc%0d: ctl=%05h ret=%0d, expected ctl=%05h ret=%0d", n, obs, retired, e.c, e.ret); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] ul [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    int n = 0;
    for (int i = 0; i < 5; i++) begin
      OP = 6'b000000; Funct = fn[i];
      push(c_fetch(1), 1, 0, 0); push(c_decode(0), 1, 0, 0);
      push(c_exec(ul[i], 2'b00), 1, 0, 0); push(c_wb(1), 1, 0, 1);
      while (sb.size() != 0) begin
        e = sb.pop_front(); mem_ready = e.rdy; Zero = e.zero;
        @(negedge clk); checks++;
        if (obs !== e.c || retired !== e.ret) begin errors++;
          $display("FAIL rtype f=%b cyc%0d: ctl=%05h ret=%0d, expected ctl=%05h ret=%0d", Funct, n, obs, retired, e.c, e.ret); end
        n++; @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_itype();
    logic [5:0] op [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
    logic [2:0] ul [4] = '{3'b010, 3'b000, 3'b001, 3'b111};
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      OP = op[i]; Funct = 6'b000000;
      push(c_fetch(1), 1, 0, 0); push(c_decode(0), 1, 0, 0);
      push(c_exec(ul[i], 2'b10), 0, 0, 0); push(c_wb(0), 1, 0, 1);
      while (sb.size() != 0) begin
        e = sb.pop_front(); mem_ready = e.rdy; Zero = e.zero;
        @(negedge clk); checks++;
        if (obs !== e.c || retired !== e.ret) begin errors++;
          $display("FAIL itype op=%b cyc%0d: ctl=%05h ret=%0d, expected ctl=%05h ret=%0d", OP, n, obs, retired, e.c, e.ret); end
        n++; @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_lw_wait();
    int n = 0;
    OP = 6'b100011;
    push(c_fetch(1), 1, 0, 0); push(c_decode(0), 1, 0, 0); push(c_memadr(), 1, 0, 0);
    push(c_memread(), 0, 0, 0); push(c_memread(), 0, 0, 0); push(c_memread(), 0, 0, 0);
    push(c_memread(), 1, 0, 0); push(c_memwb(), 1, 0, 1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); mem_ready = e.rdy; Zero = e.zero;
      @(negedge clk); checks++;
      if (obs !== e.c || retired !== e.ret) begin errors++;
        $display("FAIL lw_wait cyc%0d: ctl=%05h ret=%0d, expected ctl=%05h ret=%0d", n, obs, retired, e.c, e.ret); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_fetch_wait();
    int n = 0;
    OP = 6'b101011;
    push(c_fetch(0), 0, 0, 0); push(c_fetch(0), 0, 0, 0); push(c_fetch(1), 1, 0, 0);
    push(c_decode(0), 1, 0, 0); push(c_memadr(), 1, 0, 0);
    push(c_memwrite(), 0, 0, 0); push(c_memwrite(), 1, 0, 1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); mem_ready = e.rdy; Zero = e.zero;
      @(negedge clk); checks++;
      if (obs !== e.c || retired !== e.ret) begin errors++;
        $display("FAIL sw_fetch_wait cyc%0d: ctl=%05h ret=%0d, expected ctl=%05h ret=%0d", n, obs, retired, e.c, e.ret); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [5:0] op [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    logic       z  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       pc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      OP = op[i];
      push(c_fetch(1), 1, z[i], 0); push(c_decode(0), 1, z[i], 0); push(c_branch(pc[i]), 1, z[i], 1);
      while (sb.size() != 0) begin
        e = sb.pop_front(); mem_ready = e.rdy; Zero = e.zero;
        @(negedge clk); checks++;
        if (obs !== e.c || retired !== e.ret) begin errors++;
          $display("FAIL branch op=%b z=%b cyc%0d: ctl=%05h ret=%0d, expected ctl=%05h ret=%0d", OP, Zero, n, obs, retired, e.c, e.ret); end
        n++; @(posedge clk); #1;
      end
    end
    Zero = 1'b0;
  endtask

  task automatic test_illegal();
    int n = 0;
    OP = 6'b111111; Funct = 6'b100000;
    push(c_fetch(1), 1, 0, 0); push(c_decode(1), 1, 0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); mem_ready = e.rdy; Zero = e.zero;
      @(negedge clk); checks++;
      if (obs !== e.c || retired !== e.ret) begin errors++;
        $display("FAIL illegal_op cyc%0d: ctl=%05h ret=%0d, expected ctl=%05h ret=%0d", n, obs, retired, e.c, e.ret); end
      n++; @(posedge clk); #1;
    end
    OP = 6'b000000; Funct = 6'b000000;
    push(c_fetch(1), 1, 0, 0); push(c_decode(1), 1, 0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); mem_ready = e.rdy; Zero = e.zero;
      @(negedge clk); checks++;
      if (obs !== e.c || retired !== e.ret) begin errors++;
        $display("FAIL illegal_funct cyc%0d: ctl=%05h ret=%0d, expected ctl=%05h ret=%0d", n, obs, retired, e.c, e.ret); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_jump_wrap();
    int n = 0;
    OP = 6'b000010;
    for (int i = 0; i < 5; i++) begin
      push(c_fetch(1), 1, 0, 0); push(c_decode(0), 1, 0, 0); push(c_jump(), 1, 0, 1);
    end
    push(c_fetch(0), 0, 0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); mem_ready = e.rdy; Zero = e.zero;
      @(negedge clk); checks++;
      if (obs !== e.c || retired !== e.ret) begin errors++;
        $display("FAIL jump_wrap cyc%0d: ctl=%05h ret=%0d, expected ctl=%05h ret=%0d", n, obs, retired, e.c, e.ret); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midwrite();
    int n = 0;
    OP = 6'b101011;
    push(c_fetch(1), 1, 0, 0); push(c_decode(0), 1, 0, 0); push(c_memadr(), 1, 0, 0);
    push(c_memwrite(), 0, 0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); mem_ready = e.rdy; Zero = e.zero;
      @(negedge clk); checks++;
      if (obs !== e.c || retired !== e.ret) begin errors++;
        $display("FAIL midwrite_setup cyc%0d: ctl=%05h ret=%0d, expected ctl=%05h ret=%0d", n, obs, retired, e.c, e.ret); end
      n++; @(posedge clk); #1;
    end
    mem_ready = 1'b0; #1;
    checks++;
    if ({mem_req, MemWrite} !== 2'b11) begin errors++;
      $display("FAIL midwrite_wait: mem_req/MemWrite=%b, expected 11", {mem_req, MemWrite}); end
    rst_n = 1'b0; #1;
    checks++;
    if (obs !== c_zero() || retired !== '0) begin errors++;
      $display("FAIL async_reset: ctl=%05h ret=%0d, expected ctl=00000 ret=0", obs, retired); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ret = '0;
    push(c_zero(), 1, 0, 0); push(c_fetch(1), 1, 0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); mem_ready = e.rdy; Zero = e.zero;
      @(negedge clk); checks++;
      if (obs !== e.c || retired !== e.ret) begin errors++;
        $display("FAIL post_reset cyc%0d: ctl=%05h ret=%0d, expected ctl=%05h ret=%0d", n, obs, retired, e.c, e.ret); end
      n++; @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_lw_wait();
    test_sw_fetch_wait();
    test_branch();
    test_illegal();
    test_jump_wrap();
    test_reset_midwrite();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
